rr_arbiter4: RTL

RR_ARBITER4 -- requirements
Module: rr_arbiter4

---
 rtl/rr_arbiter4.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a bounded hold time.
// A grant is kept while its owner requests, up to MAX_HOLD cycles when
// others are waiting; grant outputs are registered (one-edge latency).
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   r_hold;
  logic [CNT_W-1:0]   w_hold_nxt;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [IDX_W-1:0]   r_gnt_id;
  logic [IDX_W-1:0]   w_gnt_id_nxt;
  logic               r_gnt_valid;
  logic               w_gnt_valid_nxt;

  logic [N_REQ-1:0]   w_cand;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic               w_owner_req;
  logic               w_load;

  // The current owner is never a candidate: covers both release and preempt.
  assign w_cand      = req & ~r_gnt;
  assign w_owner_req = |(req & r_gnt);

  // First candidate in search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    logic [IDX_W-1:0] w_idx;
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = r_ptr + IDX_W'(i);
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // State register plus registered outputs; reset forces everything idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hold      <= '0;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold      <= w_hold_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_gnt_id_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
    end
  end

  // Next-state: keep, saturate, preempt, hand over or go idle.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_GRANT;
          w_load      = 1'b1;
          w_hold_nxt  = CNT_W'(1);
        end else begin
          w_hold_nxt  = '0;
        end
      end
      ST_GRANT: begin
        if (w_owner_req) begin
          if (r_hold < CNT_W'(MAX_HOLD)) begin
            w_hold_nxt = r_hold + CNT_W'(1);
          end else if (w_found) begin
            w_load     = 1'b1;
            w_hold_nxt = CNT_W'(1);
          end else begin
            w_hold_nxt = CNT_W'(MAX_HOLD);
          end
        end else if (w_found) begin
          w_load     = 1'b1;
          w_hold_nxt = CNT_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  // Output next values: new owner on a load, otherwise hold or clear.
  always_comb begin
    w_gnt_nxt       = r_gnt;
    w_gnt_id_nxt    = r_gnt_id;
    w_gnt_valid_nxt = r_gnt_valid;
    w_ptr_nxt       = r_ptr;
    if (w_load) begin
      w_gnt_nxt       = N_REQ'(1) << w_pick;
      w_gnt_id_nxt    = w_pick;
      w_gnt_valid_nxt = 1'b1;
      w_ptr_nxt       = w_pick + IDX_W'(1);
    end else if (w_state_nxt == ST_IDLE) begin
      w_gnt_nxt       = '0;
      w_gnt_id_nxt    = '0;
      w_gnt_valid_nxt = 1'b0;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;

endmodule
